// File: rtl/freq_divider_if.sv
// ---------------------------------------------------------------------------
// freq_divider_if
// Bundles the control and status signals of freq_divider.
//
// Signals:
//   en        run enable                      (master -> slave)
//   divIn     requested divisor, 8 bits       (master -> slave)
//   syncIn    phase-alignment restart request (master -> slave),
//             present only when FREQ_DIVIDER_SYNC_EN is defined
//   wave      divided square wave             (slave -> master)
//   tick      one-cycle pulse at period start (slave -> master)
//   cnt       position within the period      (slave -> master)
//   activeDiv divisor currently in force      (slave -> master)
//
// Modports: master = the controlling side, slave = the divider.
// Optional feature macro: FREQ_DIVIDER_SYNC_EN.
// ---------------------------------------------------------------------------
interface freq_divider_if;
    logic       en;
    logic [7:0] divIn;
`ifdef FREQ_DIVIDER_SYNC_EN
    logic       syncIn;
`endif
    logic       wave;
    logic       tick;
    logic [7:0] cnt;
    logic [7:0] activeDiv;

`ifdef FREQ_DIVIDER_SYNC_EN
    modport master (output en, divIn, syncIn, input wave, tick, cnt, activeDiv);
    modport slave  (input en, divIn, syncIn, output wave, tick, cnt, activeDiv);
`else
    modport master (output en, divIn, input wave, tick, cnt, activeDiv);
    modport slave  (input en, divIn, output wave, tick, cnt, activeDiv);
`endif
endinterface

// File: rtl/freq_divider.sv
// ---------------------------------------------------------------------------
// freq_divider
// Programmable clock-enable divider. Produces a near-50% square wave and a
// once-per-period tick from an 8-bit divisor (period = activeDiv+1 cycles).
// A new divisor is taken only at period boundaries so the wave never
// glitches while the regulator adjusts it.
//
// Ports:
//   clk  in   system clock, rising-edge
//   rst  in   synchronous reset, active-low
//   dv   freq_divider_if.slave:
//          en, divIn (, syncIn)       inputs
//          wave, tick, cnt, activeDiv registered outputs
//
// Parameters:
//   MIN_DIV  smallest accepted divisor (divIn below it is clamped up), 1..255
//   RST_DIV  activeDiv after reset
//
// Optional feature macro: FREQ_DIVIDER_SYNC_EN
//   Adds syncIn; while running, syncIn=1 restarts the period immediately
//   (no tick), taking priority over the normal boundary.
// ---------------------------------------------------------------------------
module freq_divider #(
    parameter int unsigned MIN_DIV = 1,
    parameter int unsigned RST_DIV = 127
) (
    input  logic          clk,
    input  logic          rst,
    freq_divider_if.slave dv
);

    localparam logic [7:0] MIN_DIV_C = 8'(MIN_DIV);
    localparam logic [7:0] RST_DIV_C = 8'(RST_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] div_q,   div_d;
    logic       wave_q,  wave_d;
    logic       tick_q,  tick_d;

    logic [7:0] div_sane;
    logic [8:0] half;
    logic       sync_req;

    always_comb begin
        div_sane = (dv.divIn < MIN_DIV_C) ? MIN_DIV_C : dv.divIn;
        // 9-bit so that activeDiv=255 yields a half point of 128
        half     = ({1'b0, div_q} + 9'd1) >> 1;
`ifdef FREQ_DIVIDER_SYNC_EN
        sync_req = dv.syncIn;
`else
        sync_req = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        wave_d  = wave_q;
        tick_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = 8'd0;
                wave_d = 1'b0;
                if (dv.en) begin
                    // start period: wave rises but no tick is issued
                    state_d = RUN;
                    div_d   = div_sane;
                    wave_d  = 1'b1;
                end
            end
            RUN: begin
                if (!dv.en) begin
                    // partial period is dropped; en low beats a boundary
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    wave_d  = 1'b0;
                end else if (sync_req) begin
                    cnt_d  = 8'd0;
                    wave_d = 1'b1;
                    div_d  = div_sane;
                end else if (cnt_q == div_q) begin
                    cnt_d  = 8'd0;
                    wave_d = 1'b1;
                    tick_d = 1'b1;
                    div_d  = div_sane;
                end else begin
                    // cnt never exceeds div_q, so the increment cannot wrap
                    cnt_d = cnt_q + 8'd1;
                    if (({1'b0, cnt_q} + 9'd1) == half)
                        wave_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                wave_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            div_q   <= RST_DIV_C;
            wave_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
        end
    end

    assign dv.wave      = wave_q;
    assign dv.tick      = tick_q;
    assign dv.cnt       = cnt_q;
    assign dv.activeDiv = div_q;

endmodule
